// File: rtl/itch_book_cmd_sched_if.sv
// Decoder-side capture inputs and book-side command handshake for itch_book_cmd_sched.
// The slave side is the scheduler; the master side is whoever drives decoders and book.
interface itch_book_cmd_sched_if;
   logic        addValid;
   logic [15:0] addLocate;
   logic [63:0] addRefNum;
   logic        addBuySell;
   logic [31:0] addShares;
   logic [31:0] addPrice;

   logic        delValid;
   logic [15:0] delLocate;
   logic [63:0] delRefNum;

   logic        execValid;
   logic [15:0] execLocate;
   logic [63:0] execRefNum;
   logic [31:0] execShares;

   logic        opValid;
   logic        opReady;
   logic [1:0]  opCode;
   logic [15:0] opLocate;
   logic [63:0] opRefNum;
   logic        opBuySell;
   logic [31:0] opShares;
   logic [31:0] opPrice;

   modport master (
      output addValid, addLocate, addRefNum, addBuySell, addShares, addPrice,
      output delValid, delLocate, delRefNum,
      output execValid, execLocate, execRefNum, execShares,
      output opReady,
      input  opValid, opCode, opLocate, opRefNum, opBuySell, opShares, opPrice
   );

   modport slave (
      input  addValid, addLocate, addRefNum, addBuySell, addShares, addPrice,
      input  delValid, delLocate, delRefNum,
      input  execValid, execLocate, execRefNum, execShares,
      input  opReady,
      output opValid, opCode, opLocate, opRefNum, opBuySell, opShares, opPrice
   );
endinterface

// File: rtl/itch_book_cmd_sched.sv
// Holds decoded ITCH add/delete/execute messages per source and serialises them
// oldest-first into a first-word fall-through command FIFO toward the order book.
module itch_book_cmd_sched #(
   parameter int FIFO_DEPTH = 16,
   parameter int HIGH_WATER = 12
) (
   input  logic                        clk,
   input  logic                        rst,
   itch_book_cmd_sched_if.slave        cmdIf,
   output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
   output logic                        fifoHighWater,
   output logic [15:0]                 dropCnt
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;
   localparam int NSRC = 3;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_DEL  = 2'b01;
   localparam logic [1:0] OP_EXEC = 2'b10;

   typedef struct packed {
      logic [1:0]  code;
      logic [15:0] locate;
      logic [63:0] refNum;
      logic        buySell;
      logic [31:0] shares;
      logic [31:0] price;
   } cmd_t;

   // Holder slots: 0 = add, 1 = exec, 2 = del; lower index wins an age tie.
   cmd_t            srcCmd  [NSRC];
   cmd_t            holdCmd [NSRC];
   logic [1:0]      holdAge [NSRC];
   logic [NSRC-1:0] srcValid;
   logic [NSRC-1:0] holdFull;
   logic [NSRC-1:0] drain;
   logic [NSRC-1:0] accept;
   logic [NSRC-1:0] drop;
   logic            anyAccept;
   logic [1:0]      selIdx;
   logic [1:0]      selAge;
   logic            selFound;
   logic            push;
   logic            pop;
   logic            fifoFull;
   logic            fifoEmpty;
   logic [AW:0]     wrPtr;
   logic [AW:0]     rdPtr;
   logic [LW-1:0]   nextLevel;
   logic [16:0]     dropSum;
   cmd_t            mem [FIFO_DEPTH];
   cmd_t            headCmd;

   always_comb begin
      srcValid  = {cmdIf.delValid, cmdIf.execValid, cmdIf.addValid};
      srcCmd[0] = '{code: OP_ADD, locate: cmdIf.addLocate, refNum: cmdIf.addRefNum,
                    buySell: cmdIf.addBuySell, shares: cmdIf.addShares, price: cmdIf.addPrice};
      srcCmd[1] = '{code: OP_EXEC, locate: cmdIf.execLocate, refNum: cmdIf.execRefNum,
                    buySell: 1'b0, shares: cmdIf.execShares, price: 32'd0};
      srcCmd[2] = '{code: OP_DEL, locate: cmdIf.delLocate, refNum: cmdIf.delRefNum,
                    buySell: 1'b0, shares: 32'd0, price: 32'd0};
   end

   always_comb begin
      selIdx   = 2'd0;
      selAge   = 2'd0;
      selFound = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (holdFull[i] && (!selFound || holdAge[i] > selAge)) begin
            selFound = 1'b1;
            selIdx   = 2'(i);
            selAge   = holdAge[i];
         end
      end
   end

   assign fifoEmpty = (wrPtr == rdPtr);
   assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign pop       = !fifoEmpty && cmdIf.opReady;
   assign push      = selFound && (!fifoFull || pop);

   // A source may reload in the same cycle its old contents move into the FIFO.
   always_comb begin
      for (int i = 0; i < NSRC; i++) begin
         drain[i]  = push && (selIdx == 2'(i));
         accept[i] = srcValid[i] && (!holdFull[i] || drain[i]);
         drop[i]   = srcValid[i] && !accept[i];
      end
      anyAccept = |accept;
      dropSum   = {1'b0, dropCnt} + 17'(drop[0]) + 17'(drop[1]) + 17'(drop[2]);
   end

   always_comb begin
      case ({push, pop})
         2'b10:   nextLevel = fifoLevel + LW'(1);
         2'b01:   nextLevel = fifoLevel - LW'(1);
         default: nextLevel = fifoLevel;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         holdFull <= '0;
         for (int i = 0; i < NSRC; i++) begin
            holdAge[i] <= 2'd0;
            holdCmd[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (accept[i]) begin
               holdFull[i] <= 1'b1;
               holdAge[i]  <= 2'd0;
               holdCmd[i]  <= srcCmd[i];
            end else if (drain[i]) begin
               holdFull[i] <= 1'b0;
            end else if (holdFull[i] && anyAccept && holdAge[i] != 2'd3) begin
               holdAge[i] <= holdAge[i] + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr         <= '0;
         rdPtr         <= '0;
         fifoLevel     <= '0;
         fifoHighWater <= 1'b0;
         dropCnt       <= 16'd0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         fifoLevel     <= nextLevel;
         fifoHighWater <= (nextLevel >= LW'(HIGH_WATER));
         dropCnt       <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      end
   end

   // Storage is left unreset; the outputs are gated by occupancy instead.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr[AW-1:0]] <= holdCmd[selIdx];
   end

   assign headCmd         = mem[rdPtr[AW-1:0]];
   assign cmdIf.opValid   = !fifoEmpty;
   assign cmdIf.opCode    = fifoEmpty ? 2'd0  : headCmd.code;
   assign cmdIf.opLocate  = fifoEmpty ? 16'd0 : headCmd.locate;
   assign cmdIf.opRefNum  = fifoEmpty ? 64'd0 : headCmd.refNum;
   assign cmdIf.opBuySell = fifoEmpty ? 1'b0  : headCmd.buySell;
   assign cmdIf.opShares  = fifoEmpty ? 32'd0 : headCmd.shares;
   assign cmdIf.opPrice   = fifoEmpty ? 32'd0 : headCmd.price;
endmodule

// File: tb/tb_itch_book_cmd_sched.sv
// Scoreboard bench for itch_book_cmd_sched: stimulus queues expected commands,
// a negedge monitor compares the FIFO head against the queue front.
module tb_itch_book_cmd_sched;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [1:0]  code;
      logic [15:0] locate;
      logic [63:0] refNum;
      logic        buySell;
      logic [31:0] shares;
      logic [31:0] price;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [4:0]  fifoLevel;
   logic        fifoHighWater;
   logic [15:0] dropCnt;
   int          vectors;
   int          miscompares;
   exp_t        expQ[$];

   itch_book_cmd_sched_if bus ();

   itch_book_cmd_sched #(.FIFO_DEPTH(DEPTH), .HIGH_WATER(12)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmdIf         (bus),
      .fifoLevel     (fifoLevel),
      .fifoHighWater (fifoHighWater),
      .dropCnt       (dropCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h", name, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearValids();
      bus.addValid  = 1'b0;
      bus.delValid  = 1'b0;
      bus.execValid = 1'b0;
   endtask

   task automatic sendAdd(input logic [15:0] loc, input logic [63:0] rn, input logic bs,
                          input logic [31:0] sh, input logic [31:0] pr, input bit expectIt);
      exp_t e;
      bus.addValid = 1'b1; bus.addLocate = loc; bus.addRefNum = rn;
      bus.addBuySell = bs; bus.addShares = sh; bus.addPrice = pr;
      e.code = 2'b00; e.locate = loc; e.refNum = rn; e.buySell = bs; e.shares = sh; e.price = pr;
      if (expectIt) expQ.push_back(e);
   endtask

   task automatic sendExec(input logic [15:0] loc, input logic [63:0] rn, input logic [31:0] sh);
      exp_t e;
      bus.execValid = 1'b1; bus.execLocate = loc; bus.execRefNum = rn; bus.execShares = sh;
      e.code = 2'b10; e.locate = loc; e.refNum = rn; e.buySell = 1'b0; e.shares = sh; e.price = 32'd0;
      expQ.push_back(e);
   endtask

   task automatic sendDel(input logic [15:0] loc, input logic [63:0] rn);
      exp_t e;
      bus.delValid = 1'b1; bus.delLocate = loc; bus.delRefNum = rn;
      e.code = 2'b01; e.locate = loc; e.refNum = rn; e.buySell = 1'b0; e.shares = 32'd0; e.price = 32'd0;
      expQ.push_back(e);
   endtask

   task automatic waitDrain(input string name, input int budget);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("FAIL %s drain_timeout left=%0d exp=0", name, expQ.size());
      end
   endtask

   // Monitor: whenever a command is presented it must equal the oldest expected one.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clk);
         if (!rst && bus.opValid) begin
            a.code = bus.opCode; a.locate = bus.opLocate; a.refNum = bus.opRefNum;
            a.buySell = bus.opBuySell; a.shares = bus.opShares; a.price = bus.opPrice;
            vectors++;
            if (expQ.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_cmd code=%0h ref=%0h exp=none", a.code, a.refNum);
            end else begin
               e = expQ[0];
               if (a !== e) begin
                  miscompares++;
                  $display("FAIL cmd got code=%0h loc=%0h ref=%0h bs=%0b sh=%0h pr=%0h exp code=%0h loc=%0h ref=%0h bs=%0b sh=%0h pr=%0h",
                           a.code, a.locate, a.refNum, a.buySell, a.shares, a.price,
                           e.code, e.locate, e.refNum, e.buySell, e.shares, e.price);
               end
               if (bus.opReady) void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      int sent;
      int src;
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      clearValids();
      bus.addLocate = '0; bus.addRefNum = '0; bus.addBuySell = 1'b0; bus.addShares = '0; bus.addPrice = '0;
      bus.delLocate = '0; bus.delRefNum = '0;
      bus.execLocate = '0; bus.execRefNum = '0; bus.execShares = '0;
      bus.opReady = 1'b0;
      tick(); tick();
      check("rst_opValid", 64'(bus.opValid), 64'd0);
      check("rst_fifoLevel", 64'(fifoLevel), 64'd0);
      check("rst_dropCnt", 64'(dropCnt), 64'd0);
      check("rst_highWater", 64'(fifoHighWater), 64'd0);
      check("rst_opRefNum", bus.opRefNum, 64'd0);
      rst = 1'b0;
      tick();

      // Single add: 2-cycle latency, then drained
      bus.opReady = 1'b1;
      sendAdd(16'h0001, 64'h1234, 1'b1, 32'd100, 32'h0001_86A0, 1'b1);
      tick();
      clearValids();
      check("add_lat_n", 64'(bus.opValid), 64'd0);
      tick();
      check("add_lat_n1", 64'(bus.opValid), 64'd1);
      check("add_level_1", 64'(fifoLevel), 64'd1);
      tick();
      check("add_level_0", 64'(fifoLevel), 64'd0);
      waitDrain("single_add", 20);

      // Simultaneous add/exec/del: order add, exec, del
      sendAdd(16'h0010, 64'hA0, 1'b0, 32'd5, 32'd777, 1'b1);
      sendExec(16'h0011, 64'hE0, 32'd9);
      sendDel(16'h0012, 64'hD0);
      tick();
      clearValids();
      waitDrain("triple", 30);
      check("triple_dropCnt", 64'(dropCnt), 64'd0);

      // Overflow: 20 adds while stalled; pulses 17..19 dropped
      bus.opReady = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sendAdd(16'h0100, 64'h5000 + 64'(i), 1'b1, 32'(i), 32'(i * 3), i <= 16);
         tick();
         check("ovf_level", 64'(fifoLevel), 64'((i < 16) ? i : 16));
         check("ovf_highWater", 64'(fifoHighWater), 64'((i >= 12) ? 1 : 0));
      end
      clearValids();
      tick();
      check("ovf_level_full", 64'(fifoLevel), 64'd16);
      check("ovf_dropCnt", 64'(dropCnt), 64'd3);
      bus.opReady = 1'b1;
      waitDrain("ovf_drain", 60);
      check("ovf_level_after", 64'(fifoLevel), 64'd0);

      // Age ordering while FIFO full: exec then delete two cycles later
      bus.opReady = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sendAdd(16'h0200, 64'h6000 + 64'(i), 1'b0, 32'd1, 32'd2, 1'b1);
         tick();
      end
      clearValids();
      tick(); tick();
      check("age_full", 64'(fifoLevel), 64'd16);
      sendExec(16'h0201, 64'h7001, 32'd44);
      tick();
      clearValids();
      tick();
      sendDel(16'h0202, 64'h7002);
      tick();
      clearValids();
      tick();
      bus.opReady = 1'b1;
      waitDrain("age_drain", 60);
      check("age_dropCnt", 64'(dropCnt), 64'd3);

      // Random stalls over 1000 mixed messages; outstanding kept below FIFO depth
      sent = 0;
      for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
         clearValids();
         bus.opReady = 1'($urandom_range(0, 1));
         if (expQ.size() < DEPTH - 1 && $urandom_range(0, 3) != 0) begin
            src = $urandom_range(0, 2);
            case (src)
               0: sendAdd(16'($urandom), {$urandom, $urandom}, 1'($urandom), $urandom, $urandom, 1'b1);
               1: sendExec(16'($urandom), {$urandom, $urandom}, $urandom);
               default: sendDel(16'($urandom), {$urandom, $urandom});
            endcase
            sent++;
         end
         tick();
      end
      clearValids();
      check("rand_sent", 64'(sent), 64'd1000);
      bus.opReady = 1'b1;
      waitDrain("rand_drain", 100);
      check("rand_dropCnt", 64'(dropCnt), 64'd3);

      // Reset with 5 queued and 2 held
      bus.opReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sendAdd(16'h0300, 64'h8000 + 64'(i), 1'b1, 32'd1, 32'd1, 1'b1);
         tick();
      end
      sendAdd(16'h0300, 64'h8004, 1'b1, 32'd1, 32'd1, 1'b1);
      sendExec(16'h0301, 64'h8005, 32'd2);
      sendDel(16'h0302, 64'h8006);
      tick();
      clearValids();
      tick();
      check("pre_rst_level", 64'(fifoLevel), 64'd5);
      rst = 1'b1;
      #1;
      expQ.delete();
      check("mid_rst_opValid", 64'(bus.opValid), 64'd0);
      check("mid_rst_level", 64'(fifoLevel), 64'd0);
      check("mid_rst_dropCnt", 64'(dropCnt), 64'd0);
      tick(); tick();
      rst = 1'b0;
      bus.opReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_idle", 64'(bus.opValid), 64'd0);
      end
      sendAdd(16'h0400, 64'h9999, 1'b0, 32'd12, 32'd34, 1'b1);
      tick();
      clearValids();
      check("post_rst_lat_n", 64'(bus.opValid), 64'd0);
      tick();
      check("post_rst_lat_n1", 64'(bus.opValid), 64'd1);
      waitDrain("post_rst", 20);

      tick(); tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
